// File: rtl/clk_enable_bank.sv
// rtl/clk_enable_bank.sv - bank of NCH independent wrap counters producing tick pulses and toggle enables
// Optional macro CLK_ENABLE_BANK_SYNC_EN adds sync_in, which realigns every channel at once.
module clk_enable_bank #(
    parameter int          NCH         = 2,
    parameter int          W           = 27,
    parameter int unsigned DEFAULT_MAX = 99999999
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
`ifdef CLK_ENABLE_BANK_SYNC_EN
    input  logic           sync_in,
`endif
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [2:0]     cfg_ch,
    input  logic [W-1:0]   cfg_max,
    input  logic           cfg_mode,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] clk_enable
);

    localparam logic [W-1:0] DEF_MAX = W'(DEFAULT_MAX);

    logic [W-1:0]   cnt_q    [NCH];
    logic [W-1:0]   cnt_d    [NCH];
    logic [W-1:0]   max_q    [NCH];
    logic [W-1:0]   max_d    [NCH];
    logic [W-1:0]   sh_max_q [NCH];
    logic [W-1:0]   sh_max_d [NCH];
    logic [NCH-1:0] mode_q, mode_d;
    logic [NCH-1:0] sh_mode_q, sh_mode_d;
    logic [NCH-1:0] level_q, level_d;
    logic [NCH-1:0] tick_q, tick_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] wrap_c, apply_c, wr_c;

    // Out-of-range channel indices always look ready so writes to them are swallowed.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == 3'(i)) cfg_ready = ~pend_q[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]     = cnt_q[i];
            max_d[i]     = max_q[i];
            sh_max_d[i]  = sh_max_q[i];
            mode_d[i]    = mode_q[i];
            sh_mode_d[i] = sh_mode_q[i];
            level_d[i]   = level_q[i];
            pend_d[i]    = pend_q[i];
            tick_d[i]    = 1'b0;

            wrap_c[i]  = run && (cnt_q[i] == max_q[i]);
            apply_c[i] = pend_q[i] && (wrap_c[i] || !run);
            wr_c[i]    = cfg_valid && cfg_ready && (cfg_ch == 3'(i));

            if (run) begin
                cnt_d[i] = wrap_c[i] ? '0 : cnt_q[i] + W'(1);
            end
            if (wrap_c[i]) begin
                level_d[i] = ~level_q[i];
                tick_d[i]  = 1'b1;
            end
`ifdef CLK_ENABLE_BANK_SYNC_EN
            if (sync_in) begin
                cnt_d[i]   = '0;
                level_d[i] = 1'b0;
                tick_d[i]  = 1'b0;
                apply_c[i] = pend_q[i];
            end
`endif
            // A write needs pend_q low and an apply needs it high, so the two never collide.
            if (apply_c[i]) begin
                max_d[i]  = sh_max_q[i];
                mode_d[i] = sh_mode_q[i];
                pend_d[i] = 1'b0;
            end
            if (wr_c[i]) begin
                sh_max_d[i]  = cfg_max;
                sh_mode_d[i] = cfg_mode;
                pend_d[i]    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= '0;
                max_q[i]    <= DEF_MAX;
                sh_max_q[i] <= DEF_MAX;
            end
            mode_q    <= '1;
            sh_mode_q <= '1;
            level_q   <= '0;
            tick_q    <= '0;
            pend_q    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                max_q[i]    <= max_d[i];
                sh_max_q[i] <= sh_max_d[i];
            end
            mode_q    <= mode_d;
            sh_mode_q <= sh_mode_d;
            level_q   <= level_d;
            tick_q    <= tick_d;
            pend_q    <= pend_d;
        end
    end

    assign tick = tick_q;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            clk_enable[i] = mode_q[i] ? level_q[i] : tick_q[i];
        end
    end

endmodule

// File: tb/tb_clk_enable_bank.sv
// tb/tb_clk_enable_bank.sv - directed bench for clk_enable_bank (NCH=2, W=4, DEFAULT_MAX=3)
module tb_clk_enable_bank;

    logic       clk = 1'b0;
    logic       rst_n, run, cfg_valid, cfg_ready, cfg_mode;
    logic [2:0] cfg_ch;
    logic [3:0] cfg_max;
    logic [1:0] tick, clk_enable;
`ifdef CLK_ENABLE_BANK_SYNC_EN
    logic       sync_in;
`endif
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    clk_enable_bank #(.NCH(2), .W(4), .DEFAULT_MAX(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
`ifdef CLK_ENABLE_BANK_SYNC_EN
        .sync_in    (sync_in),
`endif
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_max    (cfg_max),
        .cfg_mode   (cfg_mode),
        .tick       (tick),
        .clk_enable (clk_enable)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; cfg_valid = 1'b0;
        cfg_ch = 3'd0; cfg_max = 4'd0; cfg_mode = 1'b0;
`ifdef CLK_ENABLE_BANK_SYNC_EN
        sync_in = 1'b0;
`endif
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0; run = 1'b1; cfg_valid = 1'b1; cfg_max = 4'd1;
        step(); step();
        tests++; if (tick !== 2'b00) begin fails++; $display("FAIL reset_tick got %b want 00", tick); end
        tests++; if (clk_enable !== 2'b00) begin fails++; $display("FAIL reset_ce got %b want 00", clk_enable); end
        for (int c = 0; c < 2; c++) begin
            cfg_ch = 3'(c); #1;
            tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_ready ch%0d got %b want 1", c, cfg_ready); end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_toggle();
        logic [1:0] et, ec;
        do_reset(); run = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            et = (k % 4 == 0) ? 2'b11 : 2'b00;
            ec = ((k / 4) % 2 == 1) ? 2'b11 : 2'b00;
            tests++; if (tick !== et) begin fails++; $display("FAIL toggle_tick k=%0d got %b want %b", k, tick, et); end
            tests++; if (clk_enable !== ec) begin fails++; $display("FAIL toggle_ce k=%0d got %b want %b", k, clk_enable, ec); end
        end
    endtask

    task automatic test_write_mid();
        logic [1:0] et [4];
        logic [1:0] ec [4];
        et = '{2'b00, 2'b01, 2'b00, 2'b11};
        ec = '{2'b10, 2'b11, 2'b10, 2'b01};
        do_reset(); run = 1'b1;
        step();
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_max = 4'd1; cfg_mode = 1'b0; #1;
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL wr_ready_pre got %b want 1", cfg_ready); end
        step(); cfg_valid = 1'b0; #1;
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL wr_ready_pend got %b want 0", cfg_ready); end
        step();
        tests++; if (cfg_ready !== 1'b0 || tick !== 2'b00) begin fails++; $display("FAIL wr_old_period ready=%b tick=%b want 0/00", cfg_ready, tick); end
        step();
        tests++; if (tick !== 2'b11 || clk_enable !== 2'b11) begin fails++; $display("FAIL wr_wrap tick=%b ce=%b want 11/11", tick, clk_enable); end
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL wr_ready_post got %b want 1", cfg_ready); end
        for (int k = 0; k < 4; k++) begin
            step();
            tests++; if (tick !== et[k] || clk_enable !== ec[k]) begin fails++; $display("FAIL wr_new_period k=%0d tick=%b ce=%b want %b/%b", k, tick, clk_enable, et[k], ec[k]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] et [3];
        logic [1:0] ec [3];
        et = '{2'b00, 2'b01, 2'b10};
        ec = '{2'b10, 2'b11, 2'b00};
        do_reset(); run = 1'b1;
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_max = 4'd2; cfg_mode = 1'b1;
        step();
        cfg_max = 4'd0; cfg_mode = 1'b0; #1;
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL b2b_ch1_stall got %b want 0", cfg_ready); end
        step();
        cfg_ch = 3'd0; cfg_max = 4'd1; cfg_mode = 1'b0; #1;
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL b2b_ch0_ready got %b want 1", cfg_ready); end
        step(); cfg_valid = 1'b0; #1;
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL b2b_ch0_pend got %b want 0", cfg_ready); end
        cfg_ch = 3'd1; #1;
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL b2b_ch1_pend got %b want 0", cfg_ready); end
        step();
        tests++; if (tick !== 2'b11 || clk_enable !== 2'b11 || cfg_ready !== 1'b1) begin fails++; $display("FAIL b2b_wrap tick=%b ce=%b ready=%b want 11/11/1", tick, clk_enable, cfg_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            tests++; if (tick !== et[k] || clk_enable !== ec[k]) begin fails++; $display("FAIL b2b_after k=%0d tick=%b ce=%b want %b/%b", k, tick, clk_enable, et[k], ec[k]); end
        end
    endtask

    task automatic test_run_hold();
        do_reset(); run = 1'b1;
        step(); step();
        run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            tests++; if (tick !== 2'b00 || clk_enable !== 2'b00) begin fails++; $display("FAIL hold k=%0d tick=%b ce=%b want 00/00", k, tick, clk_enable); end
        end
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_max = 4'd3; cfg_mode = 1'b1;
        step(); cfg_valid = 1'b0; #1;
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL hold_accept got %b want 0", cfg_ready); end
        step();
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL hold_apply got %b want 1", cfg_ready); end
        run = 1'b1;
        step();
        tests++; if (tick !== 2'b00) begin fails++; $display("FAIL resume_1 tick=%b want 00", tick); end
        step();
        tests++; if (tick !== 2'b11 || clk_enable !== 2'b11) begin fails++; $display("FAIL resume_2 tick=%b ce=%b want 11/11", tick, clk_enable); end
    endtask

    task automatic test_cfg_range();
        do_reset();
        cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_max = 4'd0; cfg_mode = 1'b0; #1;
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL range_ready got %b want 1", cfg_ready); end
        step(); cfg_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            cfg_ch = 3'(c); #1;
            tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL range_no_pend ch%0d got %b want 1", c, cfg_ready); end
        end
        run = 1'b1;
        step(); step(); step();
        tests++; if (tick !== 2'b00) begin fails++; $display("FAIL range_period tick=%b want 00", tick); end
        step();
        tests++; if (tick !== 2'b11) begin fails++; $display("FAIL range_wrap tick=%b want 11", tick); end
    endtask

    task automatic test_max_zero_reset();
        logic [1:0] et [4];
        logic [1:0] ec [4];
        logic [1:0] t2, c2;
        et = '{2'b01, 2'b01, 2'b01, 2'b11};
        ec = '{2'b10, 2'b11, 2'b10, 2'b01};
        do_reset(); run = 1'b1;
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_max = 4'd0; cfg_mode = 1'b1;
        step(); cfg_valid = 1'b0;
        step(); step(); step();
        tests++; if (tick !== 2'b11 || clk_enable !== 2'b11) begin fails++; $display("FAIL max0_apply tick=%b ce=%b want 11/11", tick, clk_enable); end
        for (int k = 0; k < 4; k++) begin
            step();
            tests++; if (tick !== et[k] || clk_enable !== ec[k]) begin fails++; $display("FAIL max0 k=%0d tick=%b ce=%b want %b/%b", k, tick, clk_enable, et[k], ec[k]); end
        end
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_max = 4'd0; cfg_mode = 1'b0; rst_n = 1'b0;
        step();
        cfg_valid = 1'b0; #1;
        tests++; if (tick !== 2'b00 || clk_enable !== 2'b00 || cfg_ready !== 1'b1) begin fails++; $display("FAIL midreset tick=%b ce=%b ready=%b want 00/00/1", tick, clk_enable, cfg_ready); end
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            t2 = (k % 4 == 0) ? 2'b11 : 2'b00;
            c2 = ((k / 4) % 2 == 1) ? 2'b11 : 2'b00;
            tests++; if (tick !== t2 || clk_enable !== c2) begin fails++; $display("FAIL postreset k=%0d tick=%b ce=%b want %b/%b", k, tick, clk_enable, t2, c2); end
        end
    endtask

`ifdef CLK_ENABLE_BANK_SYNC_EN
    task automatic test_sync();
        do_reset(); run = 1'b1;
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_max = 4'd1; cfg_mode = 1'b1;
        step(); cfg_valid = 1'b0;
        step(); step(); step(); step();
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_max = 4'd3; cfg_mode = 1'b1;
        step(); cfg_valid = 1'b0;
        step();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0; #1;
        tests++; if (tick !== 2'b00 || clk_enable !== 2'b00 || cfg_ready !== 1'b1) begin fails++; $display("FAIL sync_edge tick=%b ce=%b ready=%b want 00/00/1", tick, clk_enable, cfg_ready); end
        for (int k = 1; k <= 4; k++) begin
            step();
            tests++; if (tick !== ((k == 4) ? 2'b11 : 2'b00)) begin fails++; $display("FAIL sync_align k=%0d tick=%b", k, tick); end
        end
        tests++; if (clk_enable !== 2'b11) begin fails++; $display("FAIL sync_level ce=%b want 11", clk_enable); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_toggle();
        test_write_mid();
        test_back_to_back();
        test_run_hold();
        test_cfg_range();
        test_max_zero_reset();
`ifdef CLK_ENABLE_BANK_SYNC_EN
        test_sync();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clk_enable_bank.md
CLK_ENABLE_BANK -- requirements
Module: clk_enable_bank

Interface
REQ-001 The block SHALL have parameter NCH, default 2, meaning the number of independent enable channels (1..8).
REQ-002 The block SHALL have parameter W, default 27, meaning the width of each channel counter and its terminal-count value.
REQ-003 The block SHALL have parameter DEFAULT_MAX, default 99999999, meaning the terminal count loaded into every channel at reset.
REQ-004 The block SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning the synchronous, active-low reset.
REQ-006 The block SHALL have port run, input, 1, meaning the global count enable; low freezes all channels.
REQ-007 The block SHALL have port cfg_valid, input, 1, meaning a configuration write request.
REQ-008 The block SHALL have port cfg_ready, output, 1, meaning the addressed channel can accept a write.
REQ-009 The block SHALL have port cfg_ch, input, 3, meaning the target channel index.
REQ-010 The block SHALL have port cfg_max, input, W, meaning the new terminal count.
REQ-011 The block SHALL have port cfg_mode, input, 1, meaning the new output mode (0 = pulse, 1 = toggle).
REQ-012 The block SHALL have port tick, output, NCH, meaning a one-cycle pulse per channel at each wrap.
REQ-013 The block SHALL have port clk_enable, output, NCH, meaning the per-channel output selected by mode.

Function
REQ-014 Each channel SHALL count while run=1: if cnt==max then cnt<=0, else cnt<=cnt+1.
REQ-015 tick[i] SHALL be registered and SHALL be high for exactly the one cycle following the edge on which channel i wraps; it SHALL be 0 otherwise.
REQ-016 Each channel SHALL hold a toggle level that inverts on every wrap edge.
REQ-017 clk_enable[i] SHALL equal tick[i] in pulse mode and the toggle level in toggle mode; in toggle mode the period is 2*(max+1) cycles.
REQ-018 max=0 SHALL produce tick high every cycle and a toggle level inverting every cycle.
REQ-019 When run=0, counters, levels and modes SHALL hold, and tick SHALL be 0; counting SHALL resume from the held value.
REQ-020 A write SHALL transfer on an edge with cfg_valid=1 and cfg_ready=1, capturing cfg_max and cfg_mode into channel cfg_ch's shadow and setting its pending flag.
REQ-021 cfg_ready SHALL be combinational and SHALL equal NOT pending[cfg_ch]; for cfg_ch>=NCH it SHALL be 1, and the write SHALL be accepted and discarded.
REQ-022 A pending shadow SHALL be applied, and pending SHALL be cleared, on the channel's next wrap edge, so the period changes glitch-free; if run=0, it SHALL be applied on the edge after acceptance.
REQ-023 Applying a shadow SHALL NOT reset the toggle level; applying on a wrap SHALL leave cnt=0.
REQ-024 Channels SHALL be fully independent: simultaneous wraps, and a wrap coinciding with a write to another channel, SHALL have no interaction.

Reset
REQ-025 While rst_n=0 at an edge: cnt=0, max=DEFAULT_MAX, mode=1, level=0, tick=0, pending=0 and shadows=DEFAULT_MAX/1 for all channels; cfg_ready SHALL read 1.
REQ-026 Reset SHALL override run and cfg traffic, including mid-count and with a write pending; a pending write SHALL be lost.

Configuration
REQ-027 With macro CLK_ENABLE_BANK_SYNC_EN defined, the block SHALL add an input sync_in, 1; a high sync_in SHALL set every cnt=0 and every level=0 on that edge, apply all pending shadows, and suppress tick that cycle, with rst_n taking priority.
REQ-028 Without CLK_ENABLE_BANK_SYNC_EN, the sync_in port and its logic SHALL be absent, and behaviour SHALL be as in REQ-014..REQ-026.

Verification (NCH=2, W=4, DEFAULT_MAX=3)
REQ-029 Bench SHALL check: release reset, run=1 -> clk_enable[0] toggles every 4 cycles (period 8), and tick[0] pulses every 4 cycles in the cycle after cnt=3.
REQ-030 Bench SHALL check: write ch0 max=1, mode=0 mid-count at cnt=1 -> old period completes, then tick=clk_enable[0] pulses every 2 cycles, and cfg_ready stays 0 for ch0 until the wrap.
REQ-031 Bench SHALL check: while ch1 is pending, a second write to ch1 stalls (cfg_ready=0) and a write to ch0 is accepted the same cycle.
REQ-032 Bench SHALL check: run=0 for 5 cycles at cnt=2 -> cnt holds at 2 with tick=0, and the wrap occurs 2 cycles after run returns to 1.
REQ-033 Bench SHALL check: max=0 -> tick is constantly 1 and the level toggles every cycle; rst_n=0 mid-operation -> all outputs are 0 on the next edge and the period returns to 8.
REQ-034 Bench SHALL check, with the macro defined: sync_in pulse with ch0 and ch1 at different counts -> both channels realign, and ticks coincide 4 cycles later.
